// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared byte type and address constants for the 1x3 router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Destination 2'b11 has no output FIFO behind it.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef logic [DEFAULT_DATA_W-1:0] byte_t;

endpackage : router_pkg

`default_nettype wire

// File: rtl/router_parity_chk.sv
// ============================================================================
// Module      : router_parity_chk
// Description : Running XOR parity, received parity capture and mismatch flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] acc_byte,
    input  logic              cap_en,
    input  logic [DATA_W-1:0] cap_byte,
    input  logic              check,
    output logic              err
);

    logic [DATA_W-1:0] r_int_par;
    logic [DATA_W-1:0] r_pkt_par;
    logic              r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_int_par <= '0;
            r_pkt_par <= '0;
            r_err     <= 1'b0;
        end else begin
            if (clear) begin
                r_int_par <= '0;
                r_err     <= 1'b0;
            end else begin
                if (acc_en) begin
                    r_int_par <= r_int_par ^ acc_byte;
                end
                // Compared every cycle the parity byte is known to be out, so the
                // flag tracks the final accumulator once it settles.
                if (check) begin
                    r_err <= (r_int_par != r_pkt_par);
                end
            end
            if (cap_en) begin
                r_pkt_par <= cap_byte;
            end
        end
    end

    assign err = r_err;

endmodule : router_parity_chk

`default_nettype wire

// File: rtl/router_register.sv
// ============================================================================
// Module      : router_register
// Description : Router datapath stage: header latch, full-FIFO parking, parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_register
    import router_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);

    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_full;
    logic [DATA_W-1:0] r_dout;
    logic              r_parity_done;
    logic              r_low_pkt_valid;

    logic              w_hdr_load;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_acc_byte;
    logic              w_par_byte;
    logic              w_pdone_set;

    assign w_hdr_load = detect_add & pkt_valid & (data_in[1:0] != ADDR_INVALID);
    assign w_acc_en   = lfd_state | (ld_state & pkt_valid & ~full_state);
    assign w_acc_byte = lfd_state ? r_header : data_in;
    // pkt_valid low while loading means data_in carries the parity byte.
    assign w_par_byte = ld_state & ~pkt_valid;
    assign w_pdone_set = (w_par_byte & ~fifo_full)
                       | (laf_state & r_low_pkt_valid & ~r_parity_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_header <= '0;
        end else if (w_hdr_load) begin
            r_header <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dout <= '0;
            r_full <= '0;
        end else begin
            if (lfd_state) begin
                r_dout <= r_header;
            end else if (ld_state && !fifo_full) begin
                r_dout <= data_in;
            end else if (laf_state) begin
                r_dout <= r_full;
            end
            // Park the byte the FIFO could not take; it is replayed in LOAD_AFTER_FULL.
            if (ld_state && fifo_full) begin
                r_full <= data_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_low_pkt_valid <= 1'b0;
            r_parity_done   <= 1'b0;
        end else begin
            if (w_par_byte) begin
                r_low_pkt_valid <= 1'b1;
            end else if (rst_int_reg) begin
                r_low_pkt_valid <= 1'b0;
            end

            if (detect_add) begin
                r_parity_done <= 1'b0;
            end else if (w_pdone_set) begin
                r_parity_done <= 1'b1;
            end
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clock    (clock),
        .reset    (reset),
        .clear    (detect_add),
        .acc_en   (w_acc_en),
        .acc_byte (w_acc_byte),
        .cap_en   (w_par_byte),
        .cap_byte (data_in),
        .check    (r_parity_done),
        .err      (err)
    );

    assign dout             = r_dout;
    assign parity_done      = r_parity_done;
    assign low_packet_valid = r_low_pkt_valid;

endmodule : router_register

`default_nettype wire

// File: tb/tb_router_register.sv
// ============================================================================
// Module      : tb_router_register
// Description : Packet-level self-checking bench for router_register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_register;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         pkt_valid;
    logic [W-1:0] data_in;
    logic         fifo_full;
    logic         detect_add;
    logic         lfd_state;
    logic         ld_state;
    logic         laf_state;
    logic         full_state;
    logic         rst_int_reg;
    logic [W-1:0] dout;
    logic         parity_done;
    logic         low_packet_valid;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference state: last accepted header and byte last launched to the FIFO.
    logic [W-1:0] m_header;
    logic [W-1:0] m_dout;
    logic [W-1:0] pay [8];

    router_register #(.DATA_W(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset       = 1'b0;
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        data_in     = W'($urandom);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'h0);
        check({tag, "_pdone"}, 32'(parity_done), 32'h0);
        check({tag, "_lpv"}, 32'(low_packet_valid), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    // Drives one packet as router_fsm would. full_idx selects the byte seeing a full
    // FIFO (0..n-1 payload, n = parity byte, -1 none); flip corrupts the parity byte.
    task automatic run_packet(input logic [W-1:0] hdr, input int n,
                              input logic [W-1:0] flip, input int full_idx);
        logic [W-1:0] par_calc;
        logic [W-1:0] par_byte;
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
        step();
        if (hdr[1:0] != 2'b11) m_header = hdr;
        check("detect_pdone", 32'(parity_done), 32'h0);
        check("detect_err", 32'(err), 32'h0);

        idle(); lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        m_dout = m_header;
        check("lfd_dout", 32'(dout), 32'(m_dout));
        par_calc = m_header;

        for (int i = 0; i < n; i++) begin
            idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay[i];
            fifo_full = (i == full_idx);
            step();
            par_calc ^= pay[i];
            if (i != full_idx) begin
                m_dout = pay[i];
                check("ld_dout", 32'(dout), 32'(m_dout));
            end else begin
                check("ld_full_hold", 32'(dout), 32'(m_dout));
                for (int k = 0; k < 3; k++) begin
                    idle(); full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1;
                    step();
                    check("full_hold", 32'(dout), 32'(m_dout));
                end
                idle(); laf_state = 1'b1; pkt_valid = 1'b1;
                step();
                m_dout = pay[i];
                check("laf_replay", 32'(dout), 32'(m_dout));
                check("laf_pdone", 32'(parity_done), 32'h0);
            end
        end

        par_byte = par_calc ^ flip;
        idle(); ld_state = 1'b1; pkt_valid = 1'b0; data_in = par_byte;
        fifo_full = (full_idx == n);
        step();
        check("par_lpv", 32'(low_packet_valid), 32'h1);
        if (full_idx != n) begin
            m_dout = par_byte;
            check("par_dout", 32'(dout), 32'(m_dout));
            check("par_pdone", 32'(parity_done), 32'h1);
        end else begin
            check("par_full_hold", 32'(dout), 32'(m_dout));
            check("par_full_pdone", 32'(parity_done), 32'h0);
            for (int k = 0; k < 2; k++) begin
                idle(); full_state = 1'b1; fifo_full = 1'b1;
                step();
                check("parfull_pdone", 32'(parity_done), 32'h0);
            end
            idle(); laf_state = 1'b1;
            step();
            m_dout = par_byte;
            check("laf_par_dout", 32'(dout), 32'(m_dout));
            check("laf_par_pdone", 32'(parity_done), 32'h1);
        end

        idle();
        step();
        check("chk_err", 32'(err), 32'(flip != '0));
        check("chk_pdone", 32'(parity_done), 32'h1);

        idle(); rst_int_reg = 1'b1;
        step();
        check("rir_lpv", 32'(low_packet_valid), 32'h0);
        check("rir_err", 32'(err), 32'(flip != '0));
        check("rir_dout", 32'(dout), 32'(m_dout));
    endtask

    initial begin
        int n;
        int fidx;
        logic [W-1:0] one;
        logic [W-1:0] flip;
        one = 1;

        // Reset with random control inputs.
        for (int c = 0; c < 2; c++) begin
            reset       = 1'b1;
            {pkt_valid, fifo_full, detect_add, lfd_state, ld_state} = 5'($urandom);
            {laf_state, full_state, rst_int_reg} = 3'($urandom);
            data_in     = W'($urandom);
            step();
        end
        m_header = '0;
        m_dout   = '0;
        check_zero("reset");

        // Clean packet: 05, 11, 22, parity 36.
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_packet(8'h05, 2, 8'h00, -1);
        // Same packet with wrong parity byte 37.
        run_packet(8'h05, 2, 8'h01, -1);
        // Full FIFO on payload byte 22.
        run_packet(8'h05, 2, 8'h00, 1);
        // Invalid address keeps the previous header.
        run_packet(8'h07, 2, 8'h00, -1);
        // Full FIFO on the parity byte.
        run_packet(8'h05, 2, 8'h00, 2);
        // Full FIFO on the last payload byte with corrupt parity.
        run_packet(8'h0A, 2, 8'h80, 1);

        // Reset in the middle of a packet discards it.
        idle(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h06;
        step();
        idle(); lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        idle(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h5A;
        step();
        idle(); reset = 1'b1; ld_state = 1'b1; pkt_valid = 1'b1;
        step();
        m_header = '0;
        m_dout   = '0;
        check_zero("midreset");
        pay[0] = 8'hC3;
        run_packet(8'hFF, 1, 8'h00, -1);

        // Randomized packets.
        for (int p = 0; p < 30; p++) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) pay[i] = W'($urandom);
            flip = ($urandom_range(2, 0) == 0) ? (one << $urandom_range(W - 1, 0)) : '0;
            fidx = ($urandom_range(1, 0) == 0) ? -1 : $urandom_range(n, 0);
            run_packet(W'($urandom), n, flip, fidx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_router_register

`default_nettype wire
